mem_bus_ctrl: RTL and testbench

- Parametrised multi-master external memory bus controller.
- Generalises the single CPU/DMA address mux and T-cycle data buffering into one block. It supports N masters, configurable address and data widths, per-master req/gnt/done handshakes, and a 4-T-cycle machine-cycle sequencer.
- Sits between the CPU/DMA engines and the memory model. It owns addr_bus, rd, wr and the read/write data buffers.

---
 rtl/mem_bus_pkg.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 62 ++++++
 rtl/mem_bus_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and helpers for the multi-master memory bus controller.
//   state_e   - machine-cycle sequencer states (IDLE, T1..T4)
//   *_C       - t_cycle output encodings
//   owner_w() - width of the owner index (min 1 bit)
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4
  } state_e;

  localparam logic [1:0] T1_C     = 2'b00;
  localparam logic [1:0] T2_C     = 2'b01;
  localparam logic [1:0] T3_C     = 2'b10;
  localparam logic [1:0] T4_C     = 2'b11;
  localparam logic [1:0] T_IDLE_C = 2'b00;

  // Owner index width; a single master still gets a 1-bit owner port.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: combinational request arbiter.
//   req   - per-master request vector
//   ptr   - round-robin priority pointer (ignored under fixed priority)
//   gnt_c - one-hot winner (all zero when no request)
//   idx_c - index of the winner (0 when no request)
// Build option: MEM_BUS_RR_EN selects round-robin; otherwise lowest index wins.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  localparam int unsigned OW          = owner_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt_c,
  output logic [OW-1:0]          idx_c
);

  if (NUM_MASTERS == 1) begin : g_single
    // Single master: nothing to arbitrate.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign gnt_c      = req;
    assign idx_c      = '0;
  end else begin : g_multi
`ifdef MEM_BUS_RR_EN
    // Round-robin: search starts at ptr and wraps.
    always_comb begin : p_rr
      logic        found;
      int unsigned j;
      gnt_c = '0;
      idx_c = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        j = (32'(ptr) + i) % NUM_MASTERS;
        if (!found && req[j]) begin
          found    = 1'b1;
          gnt_c[j] = 1'b1;
          idx_c    = OW'(j);
        end
      end
    end
`else
    // Fixed priority: scan high to low so the lowest requesting index wins.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    always_comb begin : p_fixed
      gnt_c = '0;
      idx_c = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_c    = '0;
          gnt_c[i] = 1'b1;
          idx_c    = OW'(i);
        end
      end
    end
`endif
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: multi-master external memory bus controller with a 4-T-cycle
// machine-cycle sequencer (T1..T4) and address/data buffering.
//   clk, rst          - clock (one T-cycle per clock), async active-low reset
//   req, we           - per-master request / write enable
//   m_addr, m_wdata   - flattened per-master address / write data
//   gnt, done         - one-hot accept / completion pulses
//   rdata             - shared read data buffer
//   owner, busy       - current/last owner index, access in progress
//   t_cycle           - T-cycle code (00 when idle)
//   addr_bus, data_out, data_in, rd, wr - external memory interface
// Build option: MEM_BUS_RR_EN enables round-robin arbitration.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  parameter  int unsigned ADDR_W      = 16,
  parameter  int unsigned DATA_W      = 8,
  localparam int unsigned OW          = owner_w(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        done,
  output logic [DATA_W-1:0]             rdata,
  output logic [OW-1:0]                 owner,
  output logic                          busy,
  output logic [1:0]                    t_cycle,
  output logic [ADDR_W-1:0]             addr_bus,
  output logic [DATA_W-1:0]             data_out,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          rd,
  output logic                          wr
);

  state_e                  state, state_d;
  logic                    lat_we, lat_we_d;
  logic [DATA_W-1:0]       lat_wdata, lat_wdata_d;
  logic [NUM_MASTERS-1:0]  gnt_d, done_d;
  logic [DATA_W-1:0]       rdata_d, data_out_d;
  logic [OW-1:0]           owner_d;
  logic                    busy_d, rd_d, wr_d;
  logic [1:0]              t_cycle_d;
  logic [ADDR_W-1:0]       addr_bus_d;

  logic                    start_c;
  logic [NUM_MASTERS-1:0]  arb_gnt_c;
  logic [OW-1:0]           arb_idx_c;
  logic [OW-1:0]           arb_ptr;
  logic                    sel_we_c;
  logic [ADDR_W-1:0]       sel_addr_c;
  logic [DATA_W-1:0]       sel_wdata_c;

  mem_bus_arbiter #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_arb (
    .req   (req),
    .ptr   (arb_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c)
  );

`ifdef MEM_BUS_RR_EN
  // Priority pointer moves past the master just granted.
  logic [OW-1:0] rr_ptr, rr_ptr_d;

  always_comb begin : p_rr_next
    rr_ptr_d = rr_ptr;
    if (start_c) rr_ptr_d = OW'((32'(arb_idx_c) + 1) % NUM_MASTERS);
  end

  always_ff @(posedge clk or negedge rst) begin : p_rr_reg
    if (!rst) rr_ptr <= '0;
    else      rr_ptr <= rr_ptr_d;
  end

  assign arb_ptr = rr_ptr;
`else
  assign arb_ptr = '0;
`endif

  // Mux the winning master's request fields.
  always_comb begin : p_sel
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (arb_gnt_c[i]) begin
        sel_we_c    = we[i];
        sel_addr_c  = m_addr[i*ADDR_W +: ADDR_W];
        sel_wdata_c = m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Sequencer next state and next registered outputs.
  always_comb begin : p_next
    state_d     = state;
    lat_we_d    = lat_we;
    lat_wdata_d = lat_wdata;
    gnt_d       = '0;
    done_d      = '0;
    rdata_d     = rdata;
    owner_d     = owner;
    busy_d      = busy;
    t_cycle_d   = t_cycle;
    addr_bus_d  = addr_bus;
    data_out_d  = data_out;
    rd_d        = rd;
    wr_d        = wr;
    start_c     = 1'b0;

    case (state)
      IDLE: start_c = |req;
      T1: begin
        state_d   = T2;
        t_cycle_d = T2_C;
        wr_d      = lat_we;
        if (lat_we) data_out_d = lat_wdata;
      end
      T2: begin
        state_d   = T3;
        t_cycle_d = T3_C;
      end
      T3: begin
        state_d   = T4;
        t_cycle_d = T4_C;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        if (!lat_we) rdata_d = data_in;
        done_d    = NUM_MASTERS'(1) << owner;
      end
      T4: begin
        start_c = |req;
        if (!start_c) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          t_cycle_d = T_IDLE_C;
        end
      end
      default: state_d = IDLE;
    endcase

    // New access: latch the winner and enter T1 (shared by IDLE and T4).
    if (start_c) begin
      state_d     = T1;
      t_cycle_d   = T1_C;
      busy_d      = 1'b1;
      gnt_d       = arb_gnt_c;
      owner_d     = arb_idx_c;
      lat_we_d    = sel_we_c;
      lat_wdata_d = sel_wdata_c;
      addr_bus_d  = sel_addr_c;
      rd_d        = !sel_we_c;
      wr_d        = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin : p_reg
    if (!rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      t_cycle   <= T_IDLE_C;
      addr_bus  <= '0;
      data_out  <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
    end else begin
      state     <= state_d;
      lat_we    <= lat_we_d;
      lat_wdata <= lat_wdata_d;
      gnt       <= gnt_d;
      done      <= done_d;
      rdata     <= rdata_d;
      owner     <= owner_d;
      busy      <= busy_d;
      t_cycle   <= t_cycle_d;
      addr_bus  <= addr_bus_d;
      data_out  <= data_out_d;
      rd        <= rd_d;
      wr        <= wr_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed self-checking bench for mem_bus_ctrl (2 masters,
// 16-bit address, 8-bit data). Inputs change and outputs are sampled 1 ns
// after the rising edge.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rdata;
  logic [0:0]  owner;
  logic        busy;
  logic [1:0]  t_cycle;
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        rd;
  logic        wr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_bus_ctrl #(
    .NUM_MASTERS (2),
    .ADDR_W      (16),
    .DATA_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .gnt      (gnt),
    .done     (done),
    .rdata    (rdata),
    .owner    (owner),
    .busy     (busy),
    .t_cycle  (t_cycle),
    .addr_bus (addr_bus),
    .data_out (data_out),
    .data_in  (data_in),
    .rd       (rd),
    .wr       (wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [41:0] obs;
    rst = 1'b0; req = '0; we = '0; m_addr = '0; m_wdata = '0; data_in = '0;
    tick(); tick();
    obs = {addr_bus, data_out, rdata, rd, wr, gnt, done, owner, busy, t_cycle};
    n_checks++;
    if (obs !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({busy, t_cycle, gnt} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b t_cycle=%b gnt=%b expected all 0", busy, t_cycle, gnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [41:0] obs;
    req = 2'b01; we = 2'b00; m_addr = {16'h0000, 16'hC000};
    tick();
    n_checks++;
    if (gnt !== 2'b01 || addr_bus !== 16'hC000) begin
      n_fail++;
      $display("FAIL rstmid_gnt: gnt=%b addr=%h expected 01 C000", gnt, addr_bus);
    end
    req = 2'b00;
    tick();
    n_checks++;
    if (t_cycle !== 2'b01 || rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_t2: t_cycle=%b rd=%b expected 01 1", t_cycle, rd);
    end
    #2 rst = 1'b0;
    #1;
    obs = {addr_bus, data_out, rdata, rd, wr, gnt, done, owner, busy, t_cycle};
    n_checks++;
    if (obs !== 42'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected 0", obs);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (done !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_nodone[%0d]: done=%b expected 00", i, done);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({busy, t_cycle, done, gnt, rd} !== 8'd0) begin
        n_fail++;
        $display("FAIL rstmid_idle[%0d]: busy=%b t=%b done=%b gnt=%b rd=%b expected 0",
                 i, busy, t_cycle, done, gnt, rd);
      end
    end
  endtask

  task automatic test_single_read();
    logic [8:0] obs, exp;
    req = 2'b01; we = 2'b00; m_addr = {16'h0000, 16'h1234}; data_in = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) req = 2'b00;
      obs = {gnt, done, rd, wr, busy, t_cycle};
      exp = {(i == 0) ? 2'b01 : 2'b00, (i == 3) ? 2'b01 : 2'b00,
             i < 3, 1'b0, i < 4, (i < 4) ? 2'(i) : 2'b00};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL read_ctrl[%0d]: gnt,done,rd,wr,busy,t=%b expected %b", i, obs, exp);
      end
      n_checks++;
      if (addr_bus !== 16'h1234) begin
        n_fail++;
        $display("FAIL read_addr[%0d]: addr=%h expected 1234", i, addr_bus);
      end
      if (i >= 3) begin
        n_checks++;
        if (rdata !== 8'hA5) begin
          n_fail++;
          $display("FAIL read_rdata[%0d]: rdata=%h expected A5", i, rdata);
        end
      end
    end
  endtask

  task automatic test_single_write();
    logic [8:0] obs, exp;
    req = 2'b10; we = 2'b10; m_addr = {16'hFF80, 16'h0000};
    m_wdata = {8'h5A, 8'h00}; data_in = 8'h33;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) req = 2'b00;
      obs = {gnt, done, rd, wr, busy, t_cycle};
      exp = {(i == 0) ? 2'b10 : 2'b00, (i == 3) ? 2'b10 : 2'b00,
             1'b0, (i == 1 || i == 2), i < 4, (i < 4) ? 2'(i) : 2'b00};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL write_ctrl[%0d]: gnt,done,rd,wr,busy,t=%b expected %b", i, obs, exp);
      end
      n_checks++;
      if (addr_bus !== 16'hFF80 || owner !== 1'b1 || rdata !== 8'hA5) begin
        n_fail++;
        $display("FAIL write_bus[%0d]: addr=%h owner=%b rdata=%h expected FF80 1 A5",
                 i, addr_bus, owner, rdata);
      end
      if (i >= 1) begin
        n_checks++;
        if (data_out !== 8'h5A) begin
          n_fail++;
          $display("FAIL write_data[%0d]: data_out=%h expected 5A", i, data_out);
        end
      end
    end
    we = 2'b00;
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt, exp_done;
    logic [15:0] exp_addr;
    req = 2'b11; we = 2'b00; m_addr = {16'h0200, 16'h0100}; data_in = 8'h3C;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) req = 2'b10;
      if (i == 4) req = 2'b00;
      exp_gnt  = (i == 0) ? 2'b01 : (i == 4) ? 2'b10 : 2'b00;
      exp_done = (i == 3) ? 2'b01 : (i == 7) ? 2'b10 : 2'b00;
      exp_addr = (i < 4) ? 16'h0100 : 16'h0200;
      n_checks++;
      if (gnt !== exp_gnt || done !== exp_done || busy !== (i < 8)) begin
        n_fail++;
        $display("FAIL contend_ctrl[%0d]: gnt=%b done=%b busy=%b expected %b %b %b",
                 i, gnt, done, busy, exp_gnt, exp_done, (i < 8));
      end
      n_checks++;
      if (addr_bus !== exp_addr || owner !== (i >= 4)) begin
        n_fail++;
        $display("FAIL contend_owner[%0d]: addr=%h owner=%b expected %h %b",
                 i, addr_bus, owner, exp_addr, (i >= 4));
      end
    end
  endtask

  task automatic test_both_continuous();
    logic [0:0] exp_own;
    req = 2'b11; we = 2'b00; m_addr = {16'h0B0B, 16'h0A0A};
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 12) req = 2'b00;
`ifdef MEM_BUS_RR_EN
      exp_own = 1'((i / 4) % 2);
`else
      exp_own = 1'b0;
`endif
      if (i % 4 == 0 && i < 16) begin
        n_checks++;
        if (gnt !== (2'b01 << exp_own) || owner !== exp_own) begin
          n_fail++;
          $display("FAIL both_grant[%0d]: gnt=%b owner=%b expected owner %b", i, gnt, owner, exp_own);
        end
      end
      if (i == 16) begin
        n_checks++;
        if (busy !== 1'b0 || t_cycle !== 2'b00) begin
          n_fail++;
          $display("FAIL both_idle: busy=%b t=%b expected 0 00", busy, t_cycle);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    req = 2'b01; we = 2'b00; m_addr = {16'h0000, 16'h4444};
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 8) req = 2'b00;
      n_checks++;
      if (t_cycle !== ((i < 12) ? 2'(i % 4) : 2'b00) || busy !== (i < 12)) begin
        n_fail++;
        $display("FAIL b2b_tcycle[%0d]: t=%b busy=%b expected %b %b",
                 i, t_cycle, busy, (i < 12) ? 2'(i % 4) : 2'b00, (i < 12));
      end
      n_checks++;
      if (gnt !== ((i % 4 == 0 && i < 12) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d]: gnt=%b expected %b",
                 i, gnt, (i % 4 == 0 && i < 12) ? 2'b01 : 2'b00);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single_read();
    test_single_write();
    test_contention();
    test_both_continuous();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
